req_pending_ctrl: RTL
=====================

# req_pending_ctrl

Request capture and dispatch stage sitting upstream of the lowest-index-first request selection. It converts level request lines into sticky pending events via rising-edge detection, applies an enable mask, offers the lowest-index enabled pending request to a consumer through a registered valid/ack handshake, and tracks the service phase until the consumer signals completion. Events arriving on an already-pending line are coalesced and counted.

## Interface
- REQ_N, 12, number of request lines
- IDX_W, $clog2(REQ_N), width of request index
- CNT_W, 8, width of coalesced-event counter
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req  in  REQ_N  level request lines; a 0->1 transition is one event
- i_mask  in  REQ_N  1 = line enabled for dispatch; pending bits of disabled lines are retained
- i_ack  in  1  consumer accepts current offer
- i_done  in  1  consumer finished servicing accepted request
- o_valid  out  1  offer valid; o_idx is stable while high
- o_idx  out  IDX_W  index of offered / in-service request
- o_busy  out  1  high in SERVICE state
- o_pending  out  REQ_N  current pending register
- o_coal_cnt  out  CNT_W  saturating count of coalesced events

## Operation
- Edge detect: req_d <= i_req every cycle; rise = i_req & ~req_d.
- Pending update per cycle: pending <= (pending & ~clr) | rise; clr is one-hot at o_idx only in the cycle an ack is accepted; set wins over clear on the same bit (event never lost).
- Coalesce: each cycle, if (rise & pending & ~clr) != 0, o_coal_cnt += 1 (one per cycle regardless of bit count), saturating at 2^CNT_W-1.
- cand = pending & i_mask; selection = lowest set index of cand.
- FSM states IDLE, OFFER, SERVICE:
  - IDLE: if cand != 0 -> OFFER, load o_idx with selection, o_valid <= 1. Else stay.
  - OFFER: o_idx frozen, no preemption by lower-index arrivals. If i_ack -> SERVICE, o_valid <= 0, o_busy <= 1, clear pending[o_idx]. Else if i_mask[o_idx] == 0 -> IDLE, o_valid <= 0 (withdraw; pending bit kept). Ack wins over simultaneous mask drop.
  - SERVICE: o_idx held. If i_done -> IDLE, o_busy <= 0.
- i_ack outside OFFER and i_done outside SERVICE are ignored.
- Reset: state IDLE, pending 0, o_valid 0, o_busy 0, o_idx 0, o_coal_cnt 0, req_d <= i_req (lines high during reset produce no event). Reset mid-OFFER/SERVICE discards everything, no ack/done side effects.

## Timing
- i_req 0->1 sampled at edge k: pending bit set after edge k; o_valid high after edge k+1 (if masked-in and IDLE).
- Ack sampled at edge a: o_valid low, o_busy high, pending bit clear after edge a.
- Done sampled at edge d: o_busy low after d; next offer earliest after edge d+1.
- Minimum per-request cycle: offer 1, service 1, idle 1 = 3 cycles.
- All outputs registered; no combinational path from inputs to outputs.
- Fully occupied pending (all REQ_N bits set) is legal; no overflow beyond the counter.

## Test plan
- Reset with i_req = 0x005 held, release, hold 10 cycles -> o_pending = 0, o_valid never asserted.
- Pulse bits 7 and 3 same cycle, mask all-ones -> o_valid after 2 edges with o_idx = 3; ack, done -> next offer o_idx = 7; pending 0 after its ack.
- During OFFER of idx 5, pulse bit 1 -> o_idx stays 5 until ack; idx 1 offered after done.
- OFFER idx 4, drop i_mask[4] with no ack -> o_valid low next cycle, o_pending[4] still 1; re-enable -> re-offered idx 4.
- In ack cycle for idx 2, new rise on bit 2 -> o_pending[2] remains 1, o_coal_cnt unchanged; re-toggle bit 2 twice while pending -> o_coal_cnt = 2; 300 coalesced events -> o_coal_cnt = 255.
- Assert i_rst during SERVICE -> next cycle o_busy 0, o_valid 0, o_pending 0, o_coal_cnt 0.

Source files
------------

// File: rtl/req_pending_ctrl.sv
// ---------------------------------------------------------------------------
// req_pending_ctrl
//
// Purpose:
//   Turns level request lines into sticky pending events by detecting rising
//   edges. It offers the lowest-index enabled pending request to a consumer
//   over a registered valid/ack handshake, then holds that request in a
//   service phase until the consumer reports completion. An event that lands
//   on a line which is already pending is merged into that pending bit and
//   counted in a saturating counter.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous, active-high reset
//   i_req       level request lines; each 0->1 transition is one event
//   i_mask      per-line dispatch enable (pending bits of disabled lines are kept)
//   i_ack       consumer accepts the current offer (honoured only while offering)
//   i_done      consumer finished the accepted request (honoured only in service)
//   o_valid     offer valid; o_idx is stable while high
//   o_idx       index of the offered / in-service request
//   o_busy      high while a request is in service
//   o_pending   current pending register
//   o_coal_cnt  saturating count of coalesced events
// ---------------------------------------------------------------------------
module req_pending_ctrl #(
    parameter int REQ_N = 12,
    parameter int IDX_W = $clog2(REQ_N),
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REQ_N-1:0] i_req,
    input  logic [REQ_N-1:0] i_mask,
    input  logic             i_ack,
    input  logic             i_done,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_busy,
    output logic [REQ_N-1:0] o_pending,
    output logic [CNT_W-1:0] o_coal_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Registered state
    state_t           r_state;
    logic [REQ_N-1:0] r_reqDly;
    logic [REQ_N-1:0] r_pending;
    logic [CNT_W-1:0] r_coalCnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_busy;

    // Combinational helpers
    state_t           w_stateNext;
    logic [IDX_W-1:0] w_idxNext;
    logic             w_validNext;
    logic             w_busyNext;
    logic [REQ_N-1:0] w_rise;
    logic [REQ_N-1:0] w_cand;
    logic             w_candAny;
    logic [IDX_W-1:0] w_sel;
    logic             w_ackTaken;
    logic [REQ_N-1:0] w_clr;
    logic [REQ_N-1:0] w_pendingNext;
    logic             w_coalesce;
    logic             w_cntSat;

    // The request delay register also loads during reset. A line that is
    // already high when reset is released therefore produces no event.
    always_ff @(posedge i_clk) begin
        r_reqDly <= i_req;
    end

    // A line produces one event on each 0->1 transition. Only lines that are
    // pending and enabled compete for the next offer.
    always_comb begin
        w_rise    = i_req & ~r_reqDly;
        w_cand    = r_pending & i_mask;
        w_candAny = |w_cand;
    end

    // Lowest-index-first selection. The loop scans from the top index down,
    // so the last match it records is the lowest set index.
    always_comb begin
        w_sel = '0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end

    // An accepted ack clears exactly the offered bit. A new rise on the same
    // bit in the same cycle sets it again, so no event is lost. That rise is
    // not counted as coalesced, because the old event has just left.
    always_comb begin
        w_ackTaken    = (r_state == ST_OFFER) && i_ack;
        w_clr         = w_ackTaken ? (REQ_N'(1) << r_idx) : '0;
        w_pendingNext = (r_pending & ~w_clr) | w_rise;
        w_coalesce    = |(w_rise & r_pending & ~w_clr);
        w_cntSat      = &r_coalCnt;
    end

    // Pending register and coalesced-event counter. The counter steps by at
    // most one per cycle, however many lines coalesce at once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
            r_coalCnt <= '0;
        end else begin
            r_pending <= w_pendingNext;
            if (w_coalesce && !w_cntSat) begin
                r_coalCnt <= r_coalCnt + 1'b1;
            end
        end
    end

    // FSM state register. The handshake outputs are registered copies of the
    // next-state decode, so no input reaches an output combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            r_valid <= w_validNext;
            r_busy  <= w_busyNext;
        end
    end

    // FSM next-state logic.
    // While offering, the index stays frozen: a lower-index arrival does not
    // preempt the current offer. An ack beats a mask drop in the same cycle.
    // A withdrawn offer keeps its pending bit, so it can be offered again.
    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_validNext = 1'b0;
        w_busyNext  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_candAny) begin
                    w_stateNext = ST_OFFER;
                    w_idxNext   = w_sel;
                    w_validNext = 1'b1;
                end
            end
            ST_OFFER: begin
                if (i_ack) begin
                    w_stateNext = ST_SERVICE;
                    w_busyNext  = 1'b1;
                end else if (!i_mask[r_idx]) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_validNext = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (i_done) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_busyNext = 1'b1;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign o_valid    = r_valid;
    assign o_idx      = r_idx;
    assign o_busy     = r_busy;
    assign o_pending  = r_pending;
    assign o_coal_cnt = r_coalCnt;

endmodule
